// File: rtl/functs.sv
// Shared fixed-point helpers and arbiter state encoding for the radio FIR chain.
package functs;

  localparam int unsigned FRAC_BITS = 10;

  typedef enum logic [1:0] {IDLE, BURST, DRAIN, RESULT} arb_state_t;

  // Q10 fractional multiply: full 64-bit signed product, arithmetic shift, keep low word.
  function automatic logic [31:0] mul_frac10_32b(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] a_ext;
    logic signed [63:0] b_ext;
    logic signed [63:0] prod;
    a_ext = $signed({{32{a[31]}}, a});
    b_ext = $signed({{32{b[31]}}, b});
    prod  = (a_ext * b_ext) >>> FRAC_BITS;
    return prod[31:0];
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational circular priority picker: the first set request at or after ptr_i wins.
module rr_pick #(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0]         gnt_o
);

  logic [N-1:0] req_rot;
  logic [N-1:0] gnt_rot;

  always_comb begin
    // Rotate so the pointer position lands on bit 0, then isolate the lowest set bit.
    req_rot = N'({req_i, req_i} >> ptr_i);
    gnt_rot = req_rot & (~req_rot + {{(N-1){1'b0}}, 1'b1});
    gnt_o   = N'({gnt_rot, gnt_rot} >> (N - 32'(ptr_i)));
  end

endmodule

// File: rtl/fir_mac_arbiter.sv
// Round-robin sequencer sharing one Q10 fractional MAC among NUM_REQ FIR channels;
// each grant covers a whole operand burst and ends with a one-cycle result pulse.
module fir_mac_arbiter #(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FRAC_BITS  = 10
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [NUM_REQ-1:0]                 req,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] op_a,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] op_b,
  input  logic [NUM_REQ-1:0]                 op_last,
  output logic [NUM_REQ-1:0]                 ack,
  output logic [NUM_REQ-1:0]                 grant,
  output logic                               busy,
  output logic [NUM_REQ-1:0]                 res_valid,
  output logic [DATA_WIDTH-1:0]              res_data
);
  import functs::*;

  localparam int unsigned PtrW  = $clog2(NUM_REQ);
  localparam int unsigned ProdW = 2 * DATA_WIDTH;

  if (FRAC_BITS != functs::FRAC_BITS) begin : g_bad_frac
    $error("fir_mac_arbiter: FRAC_BITS must be 10");
  end
  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("fir_mac_arbiter: NUM_REQ must be within 2..8");
  end

  arb_state_t              state_q, state_d;
  logic [NUM_REQ-1:0]      grant_q, grant_d, res_valid_q, res_valid_d, pick;
  logic [PtrW-1:0]         ptr_q, ptr_d, gidx;
  logic                    first_q, first_d;
  logic                    mul_v_q, mul_v_d, mul_first_q, mul_first_d, mul_last_q, mul_last_d;
  logic [DATA_WIDTH-1:0]   mul_q, mul_d, acc_q, acc_d, res_data_q, res_data_d;
  logic [DATA_WIDTH-1:0]   a_sel, b_sel, mul_res;
  logic signed [ProdW-1:0] a_ext, b_ext;
  logic                    fire, sel_last;

  rr_pick #(
    .N (NUM_REQ)
  ) u_rr_pick (
    .req_i (req),
    .ptr_i (ptr_q),
    .gnt_o (pick)
  );

  always_comb begin
    gidx = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (grant_q[k]) gidx = PtrW'(k);
    end
  end

  assign ack      = (state_q == BURST) ? (grant_q & req) : '0;
  assign fire     = |ack;
  assign sel_last = op_last[gidx];
  assign a_sel    = op_a[gidx];
  assign b_sel    = op_b[gidx];

  always_comb begin
    a_ext   = $signed({{DATA_WIDTH{a_sel[DATA_WIDTH-1]}}, a_sel});
    b_ext   = $signed({{DATA_WIDTH{b_sel[DATA_WIDTH-1]}}, b_sel});
    // Arithmetic shift floors toward minus infinity before the low word is kept.
    mul_res = DATA_WIDTH'((a_ext * b_ext) >>> FRAC_BITS);
  end

  always_comb begin
    mul_v_d     = fire;
    mul_first_d = fire & first_q;
    mul_last_d  = fire & sel_last;
    mul_d       = fire ? mul_res : mul_q;
    acc_d       = acc_q;
    if (mul_v_q) acc_d = (mul_first_q ? '0 : acc_q) + mul_q;
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    ptr_d       = ptr_q;
    first_d     = first_q;
    res_valid_d = '0;
    res_data_d  = res_data_q;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          grant_d = pick;
          first_d = 1'b1;
          state_d = BURST;
        end
      end
      BURST: begin
        if (fire) first_d = 1'b0;
        if (fire && sel_last) state_d = DRAIN;
      end
      // The last product is being summed this cycle, so acc_q is final in RESULT.
      DRAIN: begin
        if (mul_v_q && mul_last_q) state_d = RESULT;
      end
      RESULT: begin
        res_valid_d = grant_q;
        res_data_d  = acc_q;
        ptr_d       = (gidx == PtrW'(NUM_REQ - 1)) ? '0 : gidx + PtrW'(1);
        grant_d     = '0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      ptr_q       <= '0;
      first_q     <= 1'b0;
      mul_v_q     <= 1'b0;
      mul_first_q <= 1'b0;
      mul_last_q  <= 1'b0;
      mul_q       <= '0;
      acc_q       <= '0;
      res_valid_q <= '0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      ptr_q       <= ptr_d;
      first_q     <= first_d;
      mul_v_q     <= mul_v_d;
      mul_first_q <= mul_first_d;
      mul_last_q  <= mul_last_d;
      mul_q       <= mul_d;
      acc_q       <= acc_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  end

  assign grant     = grant_q;
  assign busy      = (state_q != IDLE);
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;

endmodule

// File: doc/fir_mac_arbiter.md
Name: fir_mac_arbiter

Overview:
Round-robin arbiter and sequencer that shares one fractional multiply-accumulate engine among NUM_REQ FIR channels, for example the L+R, L-R and audio decimation filters.
- Each requester streams one burst of (coefficient, sample) operand pairs per output sample.
- The block grants the engine to one requester for a whole burst, multiplies with Q10 fixed-point scaling, accumulates, and returns one 32-bit result to the owning requester.
- It replaces the per-FIR multiplier so a single multiplier serves every filter in the radio chain.

Parameters:
NUM_REQ, 2, number of requesting FIR channels (2..8).
DATA_WIDTH, 32, operand, product and accumulator width; two's complement.
FRAC_BITS, 10, product scaling shift. Fixed at 10 to match functs::mul_frac10_32b; any other value is a compile-time error.

Ports:
clock  in  1  system clock.
reset  in  1  reset, asynchronous, active-high.
req  in  NUM_REQ  per-requester operand valid; held high while an operand pair is presented.
op_a  in  NUM_REQ x DATA_WIDTH  coefficient, per requester.
op_b  in  NUM_REQ x DATA_WIDTH  sample, per requester.
op_last  in  NUM_REQ  marks the final pair of the burst.
ack  out  NUM_REQ  one-hot; the operand pair was consumed this cycle.
grant  out  NUM_REQ  one-hot owner of the engine; zero when idle.
busy  out  1  high in every state except IDLE.
res_valid  out  NUM_REQ  one-hot, one-cycle pulse, registered.
res_data  out  DATA_WIDTH  accumulated sum; meaningful only while res_valid != 0.

Behaviour:
- Reset values:
  - state = IDLE; ack, grant, res_valid, busy, res_data = 0.
  - Round-robin pointer = 0, so requester 0 has top priority first.
  - Pipeline valid bits and accumulator = 0.
- FSM states: IDLE, BURST, DRAIN, RESULT.
- IDLE:
  - If any req is high, select the first requester at or after the pointer (circular search).
  - Register grant and go to BURST. No ack is issued in IDLE.
- BURST:
  - ack[g] = req[g] combinationally for the granted index g.
  - Non-granted requesters never see ack. Their req, op_a, op_b and op_last are ignored and must stay stable until acked.
  - req[g] low produces a bubble: no ack, grant held, no timeout.
  - When ack and op_last[g] occur together, go to DRAIN.
- Multiply stage:
  - On each ack, mul_q <= (sext64(op_a) * sext64(op_b)) >>> 10, truncated to the low 32 bits (identical to functs::mul_frac10_32b).
  - Also register mul_v, mul_first (first pair of the burst) and mul_last.
- Accumulate stage:
  - When mul_v: acc <= (mul_first ? 0 : acc) + mul_q.
  - Addition wraps modulo 2^32; no saturation.
- DRAIN: wait until mul_last has been accumulated, then go to RESULT.
- RESULT:
  - res_valid[g] = 1 and res_data = acc for exactly one cycle.
  - Pointer <= (g+1) mod NUM_REQ; grant <= 0; go to IDLE.
- Latency:
  - res_valid is high exactly 3 cycles after the cycle in which the last pair is acked.
  - First grant appears 1 cycle after req rises in IDLE.
- Burst lengths:
  - Minimum burst is 1 pair (first and last in the same ack).
  - No maximum; burst length is not parameterised here.
- Back-to-back and overlap:
  - Back-to-back bursts from the same requester are allowed only after it receives res_valid.
  - A requester re-asserting req during RESULT is seen in the following IDLE cycle.
- Reset mid-burst:
  - Everything returns to reset values and no res_valid is emitted.
  - Requesters must restart their bursts.
- Requester drops req after a partial burst: the engine stays granted indefinitely. This is legal; the bench checks there is no spurious res_valid.

Decomposition:
- Package functs (existing):
  - mul_frac10_32b;
  - FRAC_BITS constant;
  - typedef arb_state_t {IDLE, BURST, DRAIN, RESULT}.
- Sub-module rr_pick:
  - combinational circular priority picker;
  - inputs: req vector and pointer; output: one-hot grant.
  - Reusable by the later FIFO-sharing arbiter.

Test Plan:
1. Single requester, NUM_REQ=2, req[0] burst of 4 pairs: a=0x400, b=1,2,3,4 (last on 4th) -> 4 consecutive acks; res_valid[0] 3 cycles after the last ack; res_data=0x0000000A.
2. Signed scaling: one-pair burst, a=0xFFFFFFFD, b=0x400 -> res_data=0xFFFFFFFD. A second burst with a=0x200, b=0x3 -> res_data=0x00000001 (truncation toward minus infinity).
3. Contention: req[0] and req[1] rise together from reset, each with a 2-pair burst of a=0x400, b=7 -> requester 0 is served first (res 0xE); requester 1 is then granted with no ack before IDLE re-arbitration (res 0xE). Pointer ends at 0.
4. Fairness: NUM_REQ=3, all req held continuously with 1-pair bursts -> grant order 0,1,2,0,1,2; no requester is acked twice in a row.
5. Bubbles: granted requester toggles req low every other cycle during an 8-pair burst -> acks only on high cycles; sum still correct (a=0x400, b=1 each gives 8).
6. Reset mid-burst: assert reset after 2 of 4 acks -> grant, busy and res_valid = 0 immediately. A fresh 4-pair burst then produces the correct sum with no residue from the aborted burst.
